// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, scoreboard
// entry and the hard-wired zero register.
package pipeline_hazard_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         SB_SLOTS = 3;   // DX, XM, MW

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  function automatic logic src_hit(logic use_src, logic [4:0] src, sb_entry_t e);
    return use_src && (src != REG_ZERO) && e.valid && (e.rd == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hz_scoreboard.sv
// Three-slot in-flight writer scoreboard (DX, XM, MW) with source-register
// comparators; raises raw when the ID instruction reads a pending result.
module hz_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter bit WB_WRITE_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       issue,
  input  logic       kill_dx,
  output logic       raw
);

  sb_entry_t [SB_SLOTS-1:0] slot;  // [0]=DX [1]=XM [2]=MW
  sb_entry_t                id_entry;
  logic      [SB_SLOTS-1:0] hit;

  assign id_entry = '{valid: id_regwrite && (id_rd != REG_ZERO), rd: id_rd};

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot <= '0;
    end else begin
      slot[2] <= slot[1];
      slot[1] <= kill_dx ? '0 : slot[0];
      slot[0] <= issue ? id_entry : '0;
    end
  end

  // With a write-first register file the MW result is already readable in ID.
  for (genvar i = 0; i < SB_SLOTS; i++) begin : g_cmp
    localparam bit SLOT_ON = !(WB_WRITE_FIRST && (i == SB_SLOTS - 1));
    assign hit[i] = SLOT_ON &&
                    (src_hit(id_use_rs, id_rs, slot[i]) || src_hit(id_use_rt, id_rt, slot[i]));
  end

  assign raw = id_valid && (|hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: RUN/STALL/FLUSH FSM, branch > jump > RAW priority
// and saturating stall/flush statistics around the hz_scoreboard.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter bit WB_WRITE_FIRST = 1'b0,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             dx_jump,
  input  logic             xm_branch,
  output logic             pc_hold,
  output logic             fd_hold,
  output logic             dx_bubble,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e state_q, state_d;
  logic      raw_sb, raw, issue, kill_dx;

  hz_scoreboard #(.WB_WRITE_FIRST(WB_WRITE_FIRST)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .issue       (issue),
    .kill_dx     (kill_dx),
    .raw         (raw_sb)
  );

  // FD holds a squashed instruction in FLUSH, so its sources mean nothing.
  assign raw = raw_sb && (state_q != ST_FLUSH);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = ST_RUN;
    pc_hold   = 1'b0;
    fd_hold   = 1'b0;
    dx_bubble = 1'b0;
    fd_flush  = 1'b0;
    dx_flush  = 1'b0;
    issue     = 1'b0;
    kill_dx   = 1'b0;
    if (!rst) begin
      state_d = ST_RUN;
    end else if (xm_branch) begin
      fd_flush = 1'b1;
      dx_flush = 1'b1;
      kill_dx  = 1'b1;
      state_d  = ST_FLUSH;
    end else if (dx_jump) begin
      fd_flush = 1'b1;
    end else if (raw) begin
      pc_hold   = 1'b1;
      fd_hold   = 1'b1;
      dx_bubble = 1'b1;
      state_d   = ST_STALL;
    end else begin
      issue = id_valid && (state_q != ST_FLUSH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((xm_branch || dx_jump) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances (default, write-first,
// 4-bit counters) checked each cycle against a timestamp-based hazard model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, dx_jump, xm_branch;
  logic [4:0] id_rs, id_rt, id_rd;

  logic a_ph, a_fh, a_bub, a_ff, a_df;
  logic b_ph, b_fh, b_bub, b_ff, b_df;
  logic c_ph, c_fh, c_bub, c_ff, c_df;
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
  logic [3:0]  c_sc, c_fc;
  logic [4:0]  a_ctl, b_ctl, c_ctl;

  assign a_ctl = {a_ph, a_fh, a_bub, a_ff, a_df};
  assign b_ctl = {b_ph, b_fh, b_bub, b_ff, b_df};
  assign c_ctl = {c_ph, c_fh, c_bub, c_ff, c_df};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.WB_WRITE_FIRST(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .dx_jump(dx_jump), .xm_branch(xm_branch), .pc_hold(a_ph), .fd_hold(a_fh),
    .dx_bubble(a_bub), .fd_flush(a_ff), .dx_flush(a_df), .stall_cnt(a_sc), .flush_cnt(a_fc));

  pipeline_hazard_ctrl #(.WB_WRITE_FIRST(1'b1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .dx_jump(dx_jump), .xm_branch(xm_branch), .pc_hold(b_ph), .fd_hold(b_fh),
    .dx_bubble(b_bub), .fd_flush(b_ff), .dx_flush(b_df), .stall_cnt(b_sc), .flush_cnt(b_fc));

  pipeline_hazard_ctrl #(.WB_WRITE_FIRST(1'b0), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .dx_jump(dx_jump), .xm_branch(xm_branch), .pc_hold(c_ph), .fd_hold(c_fh),
    .dx_bubble(c_bub), .fd_flush(c_ff), .dx_flush(c_df), .stall_cnt(c_sc), .flush_cnt(c_fc));

  // Model: a log of issued register writes stamped with their issue cycle.
  // A result issued at cycle t is unreadable until t+4 (t+3 when write-first).
  typedef struct { int m; int rd; int cyc; } wr_t;
  wr_t lg[$];
  int  cyc = 0;
  bit  flsh [2];
  int  scnt [2];
  int  fcnt;
  int  n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit pend(int m, logic [4:0] r);
    int win = (m == 1) ? 2 : 3;
    if (r == 5'd0) return 1'b0;
    foreach (lg[i])
      if (lg[i].m == m && lg[i].rd == int'(r) && (cyc - lg[i].cyc) <= win) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_raw(int m);
    return !flsh[m] && id_valid &&
           ((id_use_rs && pend(m, id_rs)) || (id_use_rt && pend(m, id_rt)));
  endfunction

  // {pc_hold, fd_hold, dx_bubble, fd_flush, dx_flush}
  function automatic logic [4:0] m_ctl(int m);
    if (!rst)      return 5'b00000;
    if (xm_branch) return 5'b00011;
    if (dx_jump)   return 5'b00010;
    if (m_raw(m))  return 5'b11100;
    return 5'b00000;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      lg.delete();
      flsh = '{1'b0, 1'b0};
      scnt = '{0, 0};
      fcnt = 0;
    end else begin
      if (xm_branch || dx_jump) fcnt++;
      for (int m = 0; m < 2; m++) begin
        bit         r;
        logic [4:0] c;
        r = m_raw(m);
        c = m_ctl(m);
        if (c[4]) scnt[m]++;
        if (xm_branch)
          for (int i = lg.size() - 1; i >= 0; i--)
            if (lg[i].m == m && lg[i].cyc == cyc - 1) lg.delete(i);
        if (id_valid && id_regwrite && id_rd != 5'd0 && !flsh[m] && !xm_branch && !dx_jump && !r)
          lg.push_back('{m, int'(id_rd), cyc});
        flsh[m] = xm_branch;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("a.ctl", a_ctl, m_ctl(0));
      chk("b.ctl", b_ctl, m_ctl(1));
      chk("c.ctl", c_ctl, m_ctl(0));
      chk("a.stall_cnt", a_sc, scnt[0]);
      chk("b.stall_cnt", b_sc, scnt[1]);
      chk("c.stall_cnt", c_sc, (scnt[0] > 15) ? 15 : scnt[0]);
      chk("a.flush_cnt", a_fc, fcnt);
      chk("b.flush_cnt", b_fc, fcnt);
      chk("c.flush_cnt", c_fc, (fcnt > 15) ? 15 : fcnt);
    end
  end

  task automatic step(input bit r, v, input int rs, rt, input bit urs, urt,
                      input int rd, input bit rw, j, b);
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0];
    id_use_rs = urs; id_use_rt = urt; id_rd = rd[4:0]; id_regwrite = rw;
    dx_jump = j; xm_branch = b;
    @(negedge clk);
  endtask

  task automatic idle();               step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input int rd);     step(1, 1, 0, 0, 0, 0, rd, 1, 0, 0); endtask
  task automatic rdr(input int r, input bit use_rt);
    step(1, 1, use_rt ? 0 : r, use_rt ? r : 0, !use_rt, use_rt, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_rd = '0; id_regwrite = 1'b0; dx_jump = 1'b0; xm_branch = 1'b0;

    // reset with every input asserted
    step(0, 1, 3, 3, 1, 1, 3, 1, 1, 1);
    chk("rst.ctl", a_ctl, 5'b00000);
    step(0, 1, 3, 3, 1, 1, 3, 1, 1, 1);
    chk("rst.stall_cnt", a_sc, 0);
    chk("rst.flush_cnt", a_fc, 0);
    idle();
    chk("idle.ctl", a_ctl, 5'b00000);

    // back-to-back RAW on r3
    wr(3);
    for (int i = 0; i < 3; i++) begin
      rdr(3, 0);
      chk("b2b.pc_hold", a_ph, 1);
      chk("b2b.wwf_pc_hold", b_ph, (i < 2) ? 1 : 0);
    end
    rdr(3, 0);
    chk("b2b.issue", a_ph, 0);
    chk("b2b.stall_cnt", a_sc, 3);
    chk("b2b.wwf_stall_cnt", b_sc, 2);
    idle();

    // register 0 never stalls
    step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("r0.pc_hold", a_ph, 0);
    idle();
    chk("r0.stall_cnt", a_sc, 3);

    // jump squashes the r5 writer in ID
    step(1, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    chk("jmp.ctl", a_ctl, 5'b00010);
    rdr(5, 1);
    chk("jmp.fd_flush_once", a_ff, 0);
    chk("jmp.no_dx_entry", a_ph, 0);
    chk("jmp.flush_cnt", a_fc, 1);

    // branch arrives while stalled on r7
    wr(7);
    rdr(7, 0);
    chk("brs.stall", a_ph, 1);
    step(1, 1, 7, 0, 1, 0, 0, 0, 0, 1);
    chk("brs.ctl", a_ctl, 5'b00011);
    rdr(7, 0);
    chk("brs.flush_masked", a_ctl, 5'b00000);
    rdr(7, 0);
    chk("brs.run", a_ctl, 5'b00000);
    chk("brs.flush_cnt", a_fc, 2);
    chk("brs.stall_cnt", a_sc, 4);

    // reset in the middle of a stall
    wr(9);
    rdr(9, 0);
    chk("rms.stall", a_ph, 1);
    step(0, 1, 9, 0, 1, 0, 0, 0, 0, 0);
    chk("rms.rst_ctl", a_ctl, 5'b00000);
    rdr(9, 0);
    chk("rms.no_stall", a_ph, 0);
    chk("rms.stall_cnt", a_sc, 0);

    // result two slots ahead (XM) and an unused matching source
    wr(10); idle();
    rdr(10, 1); chk("xm.stall", a_ph, 1);
    rdr(10, 1); chk("xm.mw_stall", a_ph, 1);
    rdr(10, 1); chk("xm.issue", a_ph, 0);
    wr(11);
    step(1, 1, 11, 11, 0, 0, 0, 0, 0, 0);
    chk("unused.pc_hold", a_ph, 0);

    // 21 stall cycles: 4-bit counter saturates at 15
    for (int k = 1; k <= 7; k++) begin
      wr(k);
      repeat (4) rdr(k, k[0]);
    end
    chk("sat.c_stall_cnt", c_sc, 15);
    chk("sat.a_stall_cnt", a_sc, 23);
    chk("sat.b_stall_cnt", b_sc, 15);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
